// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: registered CPU/loader arbiter for the shared program/data RAM.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              clear_n_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              ldr_req_i,
    input  logic              ldr_we_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [DATA_W-1:0] ldr_wdata_i,
    output logic              ldr_gnt_o,
    output logic              ldr_rvalid_o,
    output logic [DATA_W-1:0] ldr_rdata_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [15:0]       perf_stall_o,
    output logic [15:0]       perf_ldr_o
);
    logic              cpu_gnt_q, cpu_gnt_d, ldr_gnt_q, ldr_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d, ldr_rvalid_q, ldr_rvalid_d;
    logic              ram_ce_q, ram_ce_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [7:0]        burst_q, burst_d;
    logic              cpu_elig, ldr_elig, ldr_win, cpu_win, burst_full;

    // A requester whose grant is showing this cycle sits out one arbitration round.
    assign cpu_elig   = cpu_req_i & ~cpu_gnt_q;
    assign ldr_elig   = ldr_req_i & ~ldr_gnt_q;
    assign burst_full = burst_q == 8'(MAX_BURST);
    assign ldr_win    = ldr_elig & ~(burst_full & cpu_elig);
    assign cpu_win    = cpu_elig & ~ldr_win;

    always_comb begin
        cpu_gnt_d    = cpu_win;
        ldr_gnt_d    = ldr_win;
        cpu_rvalid_d = cpu_gnt_q & ~ram_we_q;
        ldr_rvalid_d = ldr_gnt_q & ~ram_we_q;
        ram_ce_d     = cpu_win | ldr_win;
        ram_we_d     = ldr_win ? ldr_we_i : cpu_win & cpu_we_i;
        ram_addr_d   = ldr_win ? ldr_addr_i : cpu_win ? cpu_addr_i : ram_addr_q;
        ram_wdata_d  = ldr_win ? ldr_wdata_i : cpu_win ? cpu_wdata_i : ram_wdata_q;
        burst_d      = (cpu_win | ~cpu_req_i) ? 8'd0 :
                       (ldr_win & ~burst_full) ? burst_q + 8'd1 : burst_q;
    end

    always_ff @(posedge clk_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            cpu_gnt_q    <= 1'b0;
            ldr_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            burst_q      <= '0;
        end else begin
            cpu_gnt_q    <= cpu_gnt_d;
            ldr_gnt_q    <= ldr_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ldr_rvalid_q <= ldr_rvalid_d;
            ram_ce_q     <= ram_ce_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            burst_q      <= burst_d;
        end
    end

    assign cpu_gnt_o    = cpu_gnt_q;
    assign ldr_gnt_o    = ldr_gnt_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign ldr_rvalid_o = ldr_rvalid_q;
    assign cpu_rdata_o  = ram_rdata_i;
    assign ldr_rdata_o  = ram_rdata_i;
    assign cpu_stall_o  = cpu_req_i & ~cpu_gnt_q;
    assign ram_ce_o     = ram_ce_q;
    assign ram_we_o     = ram_we_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_stall_q, perf_stall_d, perf_ldr_q, perf_ldr_d;

    always_comb begin
        perf_stall_d = perf_stall_q + 16'(cpu_stall_o & (perf_stall_q != 16'hFFFF));
        perf_ldr_d   = perf_ldr_q + 16'(ldr_win & (perf_ldr_q != 16'hFFFF));
    end

    always_ff @(posedge clk_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            perf_stall_q <= '0;
            perf_ldr_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_ldr_q   <= perf_ldr_d;
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_ldr_o   = perf_ldr_q;
`else
    assign perf_stall_o = 16'h0000;
    assign perf_ldr_o   = 16'h0000;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench with a rule-level arbitration and memory model.
module tb_mem_bus_arbiter;
    localparam int MAXB = 4;

    typedef struct packed {
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
    } cmd_t;

    logic        clk = 1'b0, clear_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
    logic [7:0]  cpu_addr = '0, cpu_wdata = '0, ldr_addr = '0, ldr_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid;
    logic [7:0]  cpu_rdata, ldr_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        ram_ce, ram_we;
    logic [15:0] perf_stall, perf_ldr;

    int   checks = 0, passes = 0;
    cmd_t cpu_q[$], ldr_q[$];
    logic [7:0] cpu_rx[$], ldr_rx[$];
    logic [7:0] mem[256], sh[256];
    bit   mon_en = 0, m_cg, m_lg, m_cr, m_lr;
    int   m_b, m_stall, m_lcnt;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAXB)) dut (
        .clk_i(clk), .clear_n_i(clear_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
        .ldr_gnt_o(ldr_gnt), .ldr_rvalid_o(ldr_rvalid), .ldr_rdata_o(ldr_rdata),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata), .perf_stall_o(perf_stall), .perf_ldr_o(perf_ldr)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the read command.
    always @(posedge clk) begin
        if (ram_ce && ram_we) mem[ram_addr] <= ram_wdata;
        else if (ram_ce) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic mon_reset;
        m_cg = 0; m_lg = 0; m_cr = 0; m_lr = 0; m_b = 0; m_stall = 0; m_lcnt = 0;
        cpu_q.delete(); ldr_q.delete(); cpu_rx.delete(); ldr_rx.delete();
    endtask

    // Monitor: predicts each round from the arbitration rules and checks the DUT.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            bit   ce, le, cw, lw;
            cmd_t c;
            chk("cpu_rvalid", cpu_rvalid, m_cr);
            chk("ldr_rvalid", ldr_rvalid, m_lr);
            if (m_cr && cpu_rx.size() > 0) chk("cpu_rdata", cpu_rdata, cpu_rx.pop_front());
            if (m_lr && ldr_rx.size() > 0) chk("ldr_rdata", ldr_rdata, ldr_rx.pop_front());
            ce = cpu_req && !m_cg;
            le = ldr_req && !m_lg;
            lw = le && !(m_b == MAXB && ce);
            cw = ce && !lw;
            m_b = (cw || !cpu_req) ? 0 : (lw && m_b < MAXB) ? m_b + 1 : m_b;
            chk("cpu_gnt", cpu_gnt, cw);
            chk("ldr_gnt", ldr_gnt, lw);
            chk("cpu_stall", cpu_stall, cpu_req && !cw);
            chk("ram_ce", ram_ce, cw || lw);
            m_lcnt += int'(lw);
`ifdef ARB_PERF_CNT_EN
            chk("perf_stall", perf_stall, m_stall);
            chk("perf_ldr", perf_ldr, m_lcnt);
`else
            chk("perf_stall", perf_stall, 0);
            chk("perf_ldr", perf_ldr, 0);
`endif
            m_stall += int'(cpu_req && !cw);
            m_cr = 0;
            m_lr = 0;
            if (cw || lw) begin
                if ((cw ? cpu_q.size() : ldr_q.size()) == 0) begin
                    checks++;
                    $display("FAIL grant_without_request: cpu=%0d ldr=%0d", cw, lw);
                end else begin
                    c = cw ? cpu_q.pop_front() : ldr_q.pop_front();
                    chk("ram_we", ram_we, c.we);
                    chk("ram_addr", ram_addr, c.a);
                    chk("ram_wdata", ram_wdata, c.d);
                    if (c.we) sh[c.a] = c.d;
                    else if (cw) cpu_rx.push_back(sh[c.a]);
                    else ldr_rx.push_back(sh[c.a]);
                    m_cr = cw && !c.we;
                    m_lr = lw && !c.we;
                end
            end else chk("ram_we_idle", ram_we, 0);
            m_cg = cw;
            m_lg = lw;
        end
    end

    task automatic cpu_drv(input int n, input int idle_pct);
        cmd_t c;
        int   k;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < idle_pct) begin
                cpu_req = 0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            c.we = 1'($urandom_range(0, 1)); c.a = 8'($urandom_range(0, 15)); c.d = 8'($urandom);
            cpu_we = c.we; cpu_addr = c.a; cpu_wdata = c.d; cpu_req = 1;
            cpu_q.push_back(c);
            k = 0;
            do begin @(negedge clk); k++; end while (!cpu_gnt && k < 40);
            if (!cpu_gnt) begin checks++; $display("FAIL cpu_grant_wait: no grant in %0d cycles", k); end
        end
        cpu_req = 0;
    endtask

    task automatic ldr_drv(input int n, input int idle_pct);
        cmd_t c;
        int   k;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < idle_pct) begin
                ldr_req = 0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            c.we = 1'($urandom_range(0, 1)); c.a = 8'($urandom_range(0, 15)); c.d = 8'($urandom);
            ldr_we = c.we; ldr_addr = c.a; ldr_wdata = c.d; ldr_req = 1;
            ldr_q.push_back(c);
            k = 0;
            do begin @(negedge clk); k++; end while (!ldr_gnt && k < 40);
            if (!ldr_gnt) begin checks++; $display("FAIL ldr_grant_wait: no grant in %0d cycles", k); end
        end
        ldr_req = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt, adj;
        bit prev;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i * 7 + 3);
            sh[i]  = 8'(i * 7 + 3);
        end
        cpu_req = 1;
        repeat (2) @(negedge clk);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ldr_gnt", ldr_gnt, 0);
        chk("rst_ram_ce", ram_ce, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_cpu_stall", cpu_stall, 1);
        cpu_req = 0;
        #1;
        chk("rst_cpu_stall_low", cpu_stall, 0);
        @(negedge clk);
        clear_n = 1;
        mon_reset();
        mon_en = 1;
        // Back-to-back contention, then random traffic.
        fork
            cpu_drv(40, 0);
            ldr_drv(40, 0);
        join
        fork
            cpu_drv(200, 40);
            ldr_drv(200, 40);
        join
        repeat (4) @(negedge clk);
        mon_en = 0;
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("ldr_q_drained", ldr_q.size(), 0);
        chk("rx_drained", cpu_rx.size() + ldr_rx.size(), 0);

        // CPU read of a preset location.
        @(negedge clk);
        mem[8'h0F] = 8'hA5;
        cpu_we = 0; cpu_addr = 8'h0F; cpu_req = 1;
        tick();
        chk("t1_cpu_gnt", cpu_gnt, 1);
        chk("t1_ram_we", ram_we, 0);
        chk("t1_ram_addr", ram_addr, 8'h0F);
        @(negedge clk);
        cpu_req = 0;
        tick();
        chk("t1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_cpu_rdata", cpu_rdata, 8'hA5);
        chk("t1_cpu_gnt_off", cpu_gnt, 0);

        // Loader write followed by CPU read of the same address.
        @(negedge clk);
        ldr_we = 1; ldr_addr = 8'h10; ldr_wdata = 8'h3C; ldr_req = 1;
        tick();
        chk("t2_ldr_gnt", ldr_gnt, 1);
        chk("t2_ram_we", ram_we, 1);
        chk("t2_ram_wdata", ram_wdata, 8'h3C);
        @(negedge clk);
        ldr_req = 0; cpu_we = 0; cpu_addr = 8'h10; cpu_req = 1;
        tick();
        chk("t2_cpu_gnt", cpu_gnt, 1);
        chk("t2_ldr_rvalid", ldr_rvalid, 0);
        @(negedge clk);
        cpu_req = 0;
        tick();
        chk("t2_cpu_rvalid", cpu_rvalid, 1);
        chk("t2_cpu_rdata", cpu_rdata, 8'h3C);
        chk("t2_ldr_rvalid2", ldr_rvalid, 0);

        // Single requester holding its request for six edges.
        @(negedge clk);
        ldr_we = 0; ldr_addr = 8'h01; ldr_req = 1;
        cnt = 0; adj = 0; prev = 0;
        repeat (6) begin
            tick();
            cnt += int'(ldr_gnt);
            adj += int'(ldr_gnt && prev);
            prev = ldr_gnt;
        end
        @(negedge clk);
        ldr_req = 0;
        chk("t4_grants", cnt, 3);
        chk("t4_adjacent", adj, 0);
        repeat (2) @(negedge clk);

        // Reset during the cycle after a CPU read grant.
        cpu_we = 0; cpu_addr = 8'h0F; cpu_req = 1;
        tick();
        chk("t5_cpu_gnt", cpu_gnt, 1);
        #1 clear_n = 0;
        #1;
        chk("t5_async_gnt", cpu_gnt, 0);
        chk("t5_async_ce", ram_ce, 0);
        chk("t5_async_addr", ram_addr, 0);
        chk("t5_stall", cpu_stall, 1);
        @(negedge clk);
        cpu_req = 0;
        tick();
        chk("t5_no_rvalid", cpu_rvalid, 0);
        @(negedge clk);
        clear_n = 1;
        cpu_req = 1;
        tick();
        chk("t5_regrant", cpu_gnt, 1);
        @(negedge clk);
        cpu_req = 0;
        tick();
        chk("t5_rvalid", cpu_rvalid, 1);
        chk("t5_rdata", cpu_rdata, 8'hA5);

        // Performance counters: 10 stall cycles then 5 loader grants.
        @(negedge clk);
        clear_n = 0;
        #1;
        chk("t6_rst_stall", perf_stall, 0);
        chk("t6_rst_ldr", perf_ldr, 0);
        @(negedge clk);
        clear_n = 1;
        cpu_req = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        cpu_req = 0; ldr_req = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        ldr_req = 0;
        tick();
`ifdef ARB_PERF_CNT_EN
        chk("t6_perf_stall", perf_stall, 10);
        chk("t6_perf_ldr", perf_ldr, 5);
`else
        chk("t6_perf_stall", perf_stall, 0);
        chk("t6_perf_ldr", perf_ldr, 0);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
